// File: rtl/present_core.sv
// Iterative PRESENT cipher: one round per cycle, shared encrypt/decrypt datapath,
// with a cache of the final round key so repeat decryptions skip key preparation.
module present_core #(
    parameter int KEY_W  = 80,
    parameter int ROUNDS = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [KEY_W-1:0] key,
    input  logic [63:0]      din,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [63:0]      dout
);

    if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
        $error("present_core: KEY_W must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("present_core: ROUNDS must be in 1..31");
    end

    localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
    localparam logic [63:0] SBOX_INV = 64'hA970364BD21C8FE5;
    localparam logic [4:0]  RC_LAST  = 5'(ROUNDS);

    function automatic logic [3:0] sbox(input logic [3:0] v);
        return SBOX[{v, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] v);
        return SBOX_INV[{v, 2'b00} +: 4];
    endfunction

    typedef enum logic [2:0] {IDLE, KEYPREP, ENC, DEC, FIN} fsm_t;

    fsm_t             fsm_reg, fsm_next;
    logic [63:0]      data_reg, dout_reg;
    logic [KEY_W-1:0] key_reg, key_in_reg, cached_key_reg, cached_kl_reg;
    logic [4:0]       rc_reg;
    logic             enc_reg, cache_v_reg, done_reg;

    logic             hit;
    logic [63:0]      rk, x, enc_s, enc_p, dec_p, dec_s;
    logic [KEY_W-1:0] key_fwd, key_inv;

    assign hit = cache_v_reg && (key == cached_key_reg);
    assign rk  = key_reg[KEY_W-1 -: 64];
    assign x   = data_reg ^ rk;

    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
        assign enc_s[4*gi +: 4] = sbox(x[4*gi +: 4]);
        assign dec_s[4*gi +: 4] = sbox_inv(dec_p[4*gi +: 4]);
    end

    // pLayer moves bit i to 16*i mod 63; bit 63 stays put.
    for (genvar gi = 0; gi < 64; gi++) begin : g_perm
        localparam int PI = (gi == 63) ? 63 : (16 * gi) % 63;
        assign enc_p[PI] = enc_s[gi];
        assign dec_p[gi] = x[PI];
    end

    if (KEY_W == 80) begin : g_key80
        logic [79:0] rot, t;
        always_comb begin
            rot             = {key_reg[18:0], key_reg[79:19]};
            key_fwd         = rot;
            key_fwd[79:76]  = sbox(rot[79:76]);
            key_fwd[19:15]  = rot[19:15] ^ rc_reg;
            t               = key_reg;
            t[19:15]        = key_reg[19:15] ^ rc_reg;
            t[79:76]        = sbox_inv(key_reg[79:76]);
            key_inv         = {t[60:0], t[79:61]};
        end
    end else begin : g_key128
        logic [127:0] rot, t;
        always_comb begin
            rot              = {key_reg[66:0], key_reg[127:67]};
            key_fwd          = rot;
            key_fwd[127:124] = sbox(rot[127:124]);
            key_fwd[123:120] = sbox(rot[123:120]);
            key_fwd[66:62]   = rot[66:62] ^ rc_reg;
            t                = key_reg;
            t[66:62]         = key_reg[66:62] ^ rc_reg;
            t[127:124]       = sbox_inv(key_reg[127:124]);
            t[123:120]       = sbox_inv(key_reg[123:120]);
            key_inv          = {t[60:0], t[127:61]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fsm_reg <= IDLE;
        else      fsm_reg <= fsm_next;
    end

    always_comb begin
        fsm_next = fsm_reg;
        ready    = 1'b0;
        case (fsm_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    if (!mode)    fsm_next = ENC;
                    else if (hit) fsm_next = DEC;
                    else          fsm_next = KEYPREP;
                end
            end
            KEYPREP: if (rc_reg == RC_LAST) fsm_next = DEC;
            ENC:     if (rc_reg == RC_LAST) fsm_next = FIN;
            DEC:     if (rc_reg == 5'd1)    fsm_next = FIN;
            FIN:     fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    assign busy = ~ready;
    assign done = done_reg;
    assign dout = dout_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg       <= '0;
            dout_reg       <= '0;
            key_reg        <= '0;
            key_in_reg     <= '0;
            cached_key_reg <= '0;
            cached_kl_reg  <= '0;
            rc_reg         <= '0;
            enc_reg        <= 1'b0;
            cache_v_reg    <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (fsm_reg)
                IDLE: if (start) begin
                    data_reg   <= din;
                    key_in_reg <= key;
                    enc_reg    <= ~mode;
                    if (mode && hit) begin
                        key_reg <= cached_kl_reg;
                        rc_reg  <= RC_LAST;
                    end else begin
                        key_reg <= key;
                        rc_reg  <= 5'd1;
                    end
                end
                KEYPREP: begin
                    key_reg <= key_fwd;
                    if (rc_reg == RC_LAST) begin
                        cached_key_reg <= key_in_reg;
                        cached_kl_reg  <= key_fwd;
                        cache_v_reg    <= 1'b1;
                    end else begin
                        rc_reg <= rc_reg + 5'd1;
                    end
                end
                ENC: begin
                    data_reg <= enc_p;
                    key_reg  <= key_fwd;
                    if (rc_reg != RC_LAST) rc_reg <= rc_reg + 5'd1;
                end
                DEC: begin
                    data_reg <= dec_s;
                    key_reg  <= key_inv;
                    if (rc_reg != 5'd1) rc_reg <= rc_reg - 5'd1;
                end
                FIN: begin
                    // Key register holds K_(ROUNDS+1) after encrypt, K_1 after decrypt.
                    dout_reg <= x;
                    done_reg <= 1'b1;
                    if (enc_reg) begin
                        cached_key_reg <= key_in_reg;
                        cached_kl_reg  <= key_reg;
                        cache_v_reg    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_present_core.sv
// Directed bench for present_core: reference PRESENT vectors, latency, cache and handshake.
module tb_present_core;

    localparam logic [63:0] CT1   = 64'h5579C1387B228445;
    localparam logic [63:0] CT2   = 64'hE72C46C0F5945049;
    localparam logic [63:0] CT3   = 64'hA112FFC72F68417B;
    localparam logic [63:0] CT4   = 64'h3333DCD3213210D2;
    localparam logic [63:0] CT128 = 64'h96DB702A2E6900AF;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [127:0] K0   = '0;
    localparam logic [127:0] KF   = {128{1'b1}};

    logic clk = 1'b0;
    logic rst;
    logic start0, mode0, ready0, busy0, done0;
    logic [79:0] key0;
    logic [63:0] din0, dout0;
    logic start1, mode1, ready1, busy1, done1;
    logic [127:0] key1;
    logic [63:0] din1, dout1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    present_core #(.KEY_W(80), .ROUNDS(31)) dut80 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode0), .key(key0), .din(din0),
        .ready(ready0), .busy(busy0), .done(done0), .dout(dout0)
    );

    present_core #(.KEY_W(128), .ROUNDS(31)) dut128 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .key(key1), .din(din1),
        .ready(ready1), .busy(busy1), .done(done1), .dout(dout1)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    // Issues one request and waits for done; returns at the done cycle so the
    // next call starts back-to-back.
    task automatic run(input string tag, input bit sel, input bit m, input logic [127:0] k,
                       input logic [63:0] d, input logic [63:0] exp_d, input int exp_lat,
                       input bit noisy);
        int lat;
        bit got_done;
        logic [63:0] res;
        if (sel) begin
            start1 = 1'b1; mode1 = m; key1 = k; din1 = d;
        end else begin
            start0 = 1'b1; mode0 = m; key0 = k[79:0]; din0 = d;
        end
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        lat = 0;
        got_done = 1'b0;
        while (!got_done && lat < 150) begin
            @(posedge clk); #1;
            lat++;
            if (noisy && (lat == 10 || lat == 20)) begin
                start0 = 1'b1; mode0 = ~m; key0 = 80'h5A5A_1234_9876_ABCD_EF01; din0 = 64'hDEAD_BEEF_0BAD_F00D;
            end else begin
                start0 = 1'b0;
            end
            got_done = sel ? done1 : done0;
        end
        res = sel ? dout1 : dout0;
        check({tag, "_done"}, 128'(got_done), 128'd1);
        check({tag, "_dout"}, 128'(res), 128'(exp_d));
        check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        check({tag, "_ready"}, 128'(sel ? ready1 : ready0), 128'd1);
        check({tag, "_busy"}, 128'(sel ? busy1 : busy0), 128'd0);
        $display("txn %s: mode=%0d din=%h dout=%h latency=%0d", tag, m, d, res, lat);
    endtask

    task automatic rst_pulse();
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic count_dones(input string tag, input int cycles);
        int nd;
        nd = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done0) nd++;
        end
        check(tag, 128'(nd), 128'd0);
    endtask

    initial begin
        rst = 1'b0;
        start0 = 1'b0; mode0 = 1'b0; key0 = '0; din0 = '0;
        start1 = 1'b0; mode1 = 1'b0; key1 = '0; din1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 128'(ready0), 128'd1);
        check("rst_busy", 128'(busy0), 128'd0);
        check("rst_done", 128'(done0), 128'd0);
        check("rst_dout", 128'(dout0), 128'd0);
        check("rst_ready128", 128'(ready1), 128'd1);
        rst = 1'b1;

        run("enc_00", 0, 0, K0, 64'h0, CT1, 32, 0);
        run("enc_0F", 0, 0, KF, 64'h0, CT2, 32, 0);
        run("enc_F0", 0, 0, K0, ONES, CT3, 32, 0);
        run("enc_FF", 0, 0, KF, ONES, CT4, 32, 0);
        run("enc_noisy", 0, 0, K0, 64'h0, CT1, 32, 1);
        count_dones("noisy_extra_done", 40);
        // Encrypt under key 0 left its final round key cached.
        run("dec_after_enc", 0, 1, K0, CT1, 64'h0, 32, 0);

        rst_pulse();
        run("dec_ct1", 0, 1, K0, CT1, 64'h0, 63, 0);
        run("dec_ct2", 0, 1, KF, CT2, 64'h0, 63, 0);
        run("dec_ct3", 0, 1, K0, CT3, ONES, 63, 0);
        run("dec_ct4", 0, 1, KF, CT4, ONES, 63, 0);
        run("dec_ct4_hit", 0, 1, KF, CT4, ONES, 32, 0);
        run("dec_keyA", 0, 1, K0, CT1, 64'h0, 63, 0);
        run("dec_keyB", 0, 1, KF, CT2, 64'h0, 63, 0);
        run("dec_keyA_again", 0, 1, K0, CT1, 64'h0, 63, 0);

        // Abort a cache-hit decrypt at cycle 20 with reset.
        start0 = 1'b1; mode0 = 1'b1; key0 = '0; din0 = CT1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (19) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        check("midrst_ready", 128'(ready0), 128'd1);
        check("midrst_busy", 128'(busy0), 128'd0);
        check("midrst_done", 128'(done0), 128'd0);
        check("midrst_dout", 128'(dout0), 128'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        count_dones("midrst_no_done", 70);
        run("dec_post_rst", 0, 1, K0, CT1, 64'h0, 63, 0);
        run("dec_post_rst_hit", 0, 1, K0, CT1, 64'h0, 32, 0);

        run("enc128_00", 1, 0, K0, 64'h0, CT128, 32, 0);
        rst_pulse();
        run("dec128", 1, 1, K0, CT128, 64'h0, 63, 0);
        run("dec128_hit", 1, 1, K0, CT128, 64'h0, 32, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
